// File: rtl/ps2_pkg.sv
// ps2_pkg -- shared definitions for the PS/2 keypad decoder.
//   * key codes delivered to the consumer (0-9 digits, operators, clear)
//   * PS/2 prefix bytes (extended 0xE0, break 0xF0)
//   * prefix FSM state encoding
//   * map_code(): scan code (plus extended flag) -> key code lookup
package ps2_pkg;

  localparam logic [3:0] KEY_ADD = 4'd10;
  localparam logic [3:0] KEY_SUB = 4'd11;
  localparam logic [3:0] KEY_MUL = 4'd12;
  localparam logic [3:0] KEY_DIV = 4'd13;
  localparam logic [3:0] KEY_EQ  = 4'd14;
  localparam logic [3:0] KEY_CLR = 4'd15;

  localparam logic [7:0] PFX_EXT = 8'hE0;
  localparam logic [7:0] PFX_BRK = 8'hF0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } ps2_state_e;

  typedef struct packed {
    logic       vld;
    logic [3:0] key;
  } key_map_t;

  // Main-block digits, keypad digits and operators; only two extended codes map.
  function automatic key_map_t map_code(input logic ext, input logic [7:0] code);
    key_map_t m;
    m.vld = 1'b1;
    m.key = 4'd0;
    if (ext) begin
      case (code)
        8'h4A:   m.key = KEY_DIV;
        8'h5A:   m.key = KEY_EQ;
        default: begin
          m.vld = 1'b0;
          m.key = 4'd0;
        end
      endcase
    end else begin
      case (code)
        8'h45, 8'h70: m.key = 4'd0;
        8'h16, 8'h69: m.key = 4'd1;
        8'h1E, 8'h72: m.key = 4'd2;
        8'h26, 8'h7A: m.key = 4'd3;
        8'h25, 8'h6B: m.key = 4'd4;
        8'h2E, 8'h73: m.key = 4'd5;
        8'h36, 8'h74: m.key = 4'd6;
        8'h3D, 8'h6C: m.key = 4'd7;
        8'h3E, 8'h75: m.key = 4'd8;
        8'h46, 8'h7D: m.key = 4'd9;
        8'h79:        m.key = KEY_ADD;
        8'h7B:        m.key = KEY_SUB;
        8'h7C:        m.key = KEY_MUL;
        8'h5A:        m.key = KEY_EQ;
        8'h76, 8'h66: m.key = KEY_CLR;
        default: begin
          m.vld = 1'b0;
          m.key = 4'd0;
        end
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ps2_keydecode_if.sv
// ps2_keydecode_if -- byte input and key output bundle of the keypad decoder.
//   code_valid / code_in : one-cycle strobe with a received PS/2 byte
//   key_valid / key_data : head of the key-event buffer
//   key_ready            : consumer pop (pop when key_valid && key_ready)
//   overflow             : one-cycle pulse when a mapped key is dropped
// master = byte source / key consumer, slave = decoder.
interface ps2_keydecode_if;
  import ps2_pkg::*;

  logic       code_valid;
  logic [7:0] code_in;
  logic       key_valid;
  logic [3:0] key_data;
  logic       key_ready;
  logic       overflow;

  modport master (
    output code_valid, code_in, key_ready,
    input  key_valid, key_data, overflow
  );

  modport slave (
    input  code_valid, code_in, key_ready,
    output key_valid, key_data, overflow
  );

endinterface

// File: rtl/ps2_keydecode_key_fifo.sv
// key_fifo -- DEPTH-entry circular buffer of 4-bit key codes.
//   clk, rst        : clock, synchronous active-low reset
//   push, push_data : write request and key
//   pop_ready       : consumer ready; a pop happens when head_valid && pop_ready
//   head_valid      : buffer non-empty
//   head_data       : oldest stored key
//   overflow        : one-cycle pulse when a push is dropped (full, no pop)
module key_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [3:0] push_data,
  input  logic       pop_ready,
  output logic       head_valid,
  output logic [3:0] head_data,
  output logic       overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [3:0]    mem_r [DEPTH];
  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic [CW-1:0] count_nxt_s;
  logic          valid_r;
  logic          ovf_r;
  logic          full_s;
  logic          pop_s;
  logic          wr_en_s;
  logic          ovf_nxt_s;

  // Push/pop qualification; a full buffer still accepts a push when it pops.
  always_comb begin
    full_s      = (count_r == CNT_FULL);
    pop_s       = valid_r & pop_ready;
    wr_en_s     = push & (~full_s | pop_s);
    ovf_nxt_s   = push & full_s & ~pop_s;
    count_nxt_s = count_r;
    case ({wr_en_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_ONE;
      2'b01:   count_nxt_s = count_r - CNT_ONE;
      default: count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy, valid flag and overflow pulse.
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_nxt_s;
      valid_r <= (count_nxt_s != '0);
      ovf_r   <= ovf_nxt_s;
    end
  end

  // Storage; cleared on reset so the head reads 0 until the first key lands.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 4'd0;
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  assign head_valid = valid_r;
  assign head_data  = mem_r[rd_ptr_r];
  assign overflow   = ovf_r;

endmodule

// File: rtl/ps2_keydecode.sv
// ps2_keydecode -- turns a stream of PS/2 scan-code bytes into keypad events.
//   clk : system clock (rising edge)
//   rst : synchronous active-low reset
//   bus : ps2_keydecode_if.slave (code_valid/code_in in, key_valid/key_data/
//         overflow out, key_ready in)
// A prefix FSM tracks E0/F0, makes are mapped and pushed unless they repeat
// the currently held key (typematic), breaks release the held key. Accepted
// keys go through one register stage into key_fifo.
module ps2_keydecode
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic           clk,
  input  logic           rst,
  ps2_keydecode_if.slave bus
);

  ps2_state_e state_r;
  ps2_state_e state_nxt_s;

  logic       held_vld_r;
  logic       held_ext_r;
  logic [7:0] held_code_r;

  logic       push_r;
  logic [3:0] push_key_r;

  logic       ext_s;
  logic       brk_s;
  logic       data_byte_s;
  logic       match_s;
  logic       push_s;
  logic       held_set_s;
  logic       held_clr_s;
  key_map_t   map_s;

  logic       fifo_valid_s;
  logic [3:0] fifo_data_s;
  logic       fifo_ovf_s;

  // Prefix FSM state register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Prefix FSM next state: only E0 (from IDLE) and F0 (from IDLE/EXT) advance.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.code_valid) begin
      case (state_r)
        ST_IDLE: begin
          if (bus.code_in == PFX_EXT) begin
            state_nxt_s = ST_EXT;
          end else if (bus.code_in == PFX_BRK) begin
            state_nxt_s = ST_BRK;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_EXT: begin
          if (bus.code_in == PFX_BRK) begin
            state_nxt_s = ST_EXT_BRK;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_BRK:     state_nxt_s = ST_IDLE;
        ST_EXT_BRK: state_nxt_s = ST_IDLE;
        default:    state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // FSM outputs: classify the byte and decide push / held update.
  // A byte that leaves the FSM outside IDLE is a prefix and carries no key.
  always_comb begin
    ext_s       = (state_r == ST_EXT) || (state_r == ST_EXT_BRK);
    brk_s       = (state_r == ST_BRK) || (state_r == ST_EXT_BRK);
    data_byte_s = bus.code_valid & (state_nxt_s == ST_IDLE);
    map_s       = map_code(ext_s, bus.code_in);
    match_s     = held_vld_r & (held_ext_r == ext_s) & (held_code_r == bus.code_in);
    if (data_byte_s && !brk_s) begin
      push_s     = map_s.vld & ~match_s;
      held_set_s = map_s.vld & ~match_s;
      held_clr_s = 1'b0;
    end else if (data_byte_s && brk_s) begin
      push_s     = 1'b0;
      held_set_s = 1'b0;
      held_clr_s = match_s;
    end else begin
      push_s     = 1'b0;
      held_set_s = 1'b0;
      held_clr_s = 1'b0;
    end
  end

  // Held-key register used for typematic suppression; updated even if the
  // key is later dropped by a full buffer.
  always_ff @(posedge clk) begin
    if (!rst) begin
      held_vld_r  <= 1'b0;
      held_ext_r  <= 1'b0;
      held_code_r <= 8'h00;
    end else if (held_set_s) begin
      held_vld_r  <= 1'b1;
      held_ext_r  <= ext_s;
      held_code_r <= bus.code_in;
    end else if (held_clr_s) begin
      held_vld_r  <= 1'b0;
    end
  end

  // Push stage: accepted key enters the buffer on the following edge.
  always_ff @(posedge clk) begin
    if (!rst) begin
      push_r     <= 1'b0;
      push_key_r <= 4'd0;
    end else begin
      push_r <= push_s;
      if (push_s) begin
        push_key_r <= map_s.key;
      end
    end
  end

  key_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push_r),
    .push_data  (push_key_r),
    .pop_ready  (bus.key_ready),
    .head_valid (fifo_valid_s),
    .head_data  (fifo_data_s),
    .overflow   (fifo_ovf_s)
  );

  assign bus.key_valid = fifo_valid_s;
  assign bus.key_data  = fifo_data_s;
  assign bus.overflow  = fifo_ovf_s;

endmodule

// File: tb/tb_ps2_keydecode.sv
// tb_ps2_keydecode -- directed and random bench for ps2_keydecode.
// The reference model works on whole bytes: a pending-extended flag, a
// pending-break flag, a held key id and a queue of expected keys.
module tb_ps2_keydecode;

  localparam int DEPTH  = 4;
  localparam int POOL_N = 38;

  logic PS2_CLK = 1'b0;
  logic rst     = 1'b0;

  ps2_keydecode_if bus();

  ps2_keydecode #(.FIFO_DEPTH(DEPTH)) dut (
    .clk (PS2_CLK),
    .rst (rst),
    .bus (bus)
  );

  always #5 PS2_CLK = ~PS2_CLK;

  int n_assert = 0;
  int n_fail   = 0;
  int ovf_seen = 0;
  int exp_ovf  = 0;

  int tbl_n [256];
  int tbl_e [256];
  bit m_ext;
  bit m_brk;
  int m_held;
  int q[$];

  logic [7:0] main_d [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
  logic [7:0] pad_d  [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};
  logic [7:0] pool [POOL_N] = '{8'h16, 8'h45, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46,
                                8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D,
                                8'h79, 8'h7B, 8'h7C, 8'h5A, 8'h76, 8'h66, 8'h4A, 8'hE0, 8'hF0, 8'hF0,
                                8'hE0, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'hE1, 8'h12, 8'h1C};

  // Count every cycle the overflow pulse is seen.
  always @(negedge PS2_CLK) begin
    if (rst && bus.overflow === 1'b1) ovf_seen++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_ext  = 1'b0;
    m_brk  = 1'b0;
    m_held = -1;
    q.delete();
  endfunction

  function automatic void model_byte(input logic [7:0] b);
    int k;
    int id;
    if (!m_ext && !m_brk && b == 8'hE0) begin
      m_ext = 1'b1;
      return;
    end
    if (!m_brk && b == 8'hF0) begin
      m_brk = 1'b1;
      return;
    end
    id = (m_ext ? 256 : 0) + int'(b);
    k  = m_ext ? tbl_e[b] : tbl_n[b];
    if (m_brk) begin
      if (m_held == id) m_held = -1;
    end else if (k >= 0 && m_held != id) begin
      m_held = id;
      if (q.size() < DEPTH) q.push_back(k);
      else exp_ovf++;
    end
    m_ext = 1'b0;
    m_brk = 1'b0;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge PS2_CLK);
  endtask

  // Called at a negedge; drives a one-cycle strobe.
  task automatic send(input logic [7:0] b);
    bus.code_valid = 1'b1;
    bus.code_in    = b;
    @(negedge PS2_CLK);
    bus.code_valid = 1'b0;
    model_byte(b);
  endtask

  task automatic press(input logic [7:0] b);
    send(b);
    send(8'hF0);
    send(b);
  endtask

  task automatic drain(input string tag);
    tick(3);
    while (q.size() > 0) begin
      chk({tag, "_valid"}, {31'd0, bus.key_valid}, 32'd1);
      chk({tag, "_data"}, {28'd0, bus.key_data}, q[0]);
      bus.key_ready = 1'b1;
      @(negedge PS2_CLK);
      bus.key_ready = 1'b0;
      void'(q.pop_front());
    end
    chk({tag, "_empty"}, {31'd0, bus.key_valid}, 32'd0);
    chk({tag, "_ovf"}, ovf_seen, exp_ovf);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      tbl_n[i] = -1;
      tbl_e[i] = -1;
    end
    for (int i = 0; i < 10; i++) begin
      tbl_n[main_d[i]] = i;
      tbl_n[pad_d[i]]  = i;
    end
    tbl_n[8'h79] = 10;
    tbl_n[8'h7B] = 11;
    tbl_n[8'h7C] = 12;
    tbl_n[8'h5A] = 14;
    tbl_n[8'h76] = 15;
    tbl_n[8'h66] = 15;
    tbl_e[8'h4A] = 13;
    tbl_e[8'h5A] = 14;

    bus.code_valid = 1'b0;
    bus.code_in    = 8'h00;
    bus.key_ready  = 1'b0;
    model_reset();

    // Reset state
    rst = 1'b0;
    tick(3);
    chk("rst_valid", {31'd0, bus.key_valid}, 32'd0);
    chk("rst_data", {28'd0, bus.key_data}, 32'd0);
    chk("rst_ovf", {31'd0, bus.overflow}, 32'd0);
    rst = 1'b1;
    tick(1);

    // Single make: nothing one edge later, key 1 after the second edge
    send(8'h16);
    chk("lat_early", {31'd0, bus.key_valid}, 32'd0);
    tick(1);
    chk("lat_valid", {31'd0, bus.key_valid}, 32'd1);
    chk("lat_data", {28'd0, bus.key_data}, 32'd1);
    send(8'hF0);
    send(8'h16);
    drain("make_break");
    press(8'h16);
    drain("after_release");

    // Typematic repeats suppressed until release
    send(8'h16);
    send(8'h16);
    send(8'h16);
    send(8'hF0);
    send(8'h16);
    send(8'h16);
    drain("typematic");
    send(8'hF0);
    send(8'h16);

    // Extended keys
    send(8'hE0);
    send(8'h4A);
    send(8'hE0);
    send(8'hF0);
    send(8'h4A);
    send(8'h5A);
    send(8'hF0);
    send(8'h5A);
    drain("extended");

    // Six keys with no consumer: four stored, two overflows
    press(8'h45);
    press(8'h16);
    press(8'h1E);
    press(8'h26);
    press(8'h25);
    press(8'h2E);
    drain("overflow");

    // Full buffer, push and pop in the same cycle
    press(8'h45);
    press(8'h16);
    press(8'h1E);
    press(8'h26);
    tick(3);
    chk("full_head", {28'd0, bus.key_data}, 32'd0);
    bus.code_valid = 1'b1;
    bus.code_in    = 8'h25;
    @(negedge PS2_CLK);
    bus.code_valid = 1'b0;
    bus.key_ready  = 1'b1;
    @(negedge PS2_CLK);
    bus.key_ready  = 1'b0;
    void'(q.pop_front());
    model_byte(8'h25);
    chk("pushpop_ovf", {31'd0, bus.overflow}, 32'd0);
    drain("push_pop_full");
    send(8'hF0);
    send(8'h25);

    // Reset after a pending E0 with a strobe during reset
    send(8'h45);
    send(8'hE0);
    tick(1);
    chk("pre_rst_valid", {31'd0, bus.key_valid}, 32'd1);
    rst            = 1'b0;
    bus.code_valid = 1'b1;
    bus.code_in    = 8'h5A;
    @(negedge PS2_CLK);
    bus.code_valid = 1'b0;
    rst            = 1'b1;
    model_reset();
    chk("midrst_valid", {31'd0, bus.key_valid}, 32'd0);
    chk("midrst_data", {28'd0, bus.key_data}, 32'd0);
    tick(2);
    chk("postrst_valid", {31'd0, bus.key_valid}, 32'd0);
    send(8'h5A);
    drain("after_reset");
    send(8'hF0);
    send(8'h5A);

    // Random byte streams
    for (int r = 0; r < 40; r++) begin
      int n;
      n = $urandom_range(1, 8);
      for (int i = 0; i < n; i++) begin
        send(pool[$urandom_range(0, POOL_N - 1)]);
      end
      drain("random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/ps2_keydecode.md
PS2_KEYDECODE -- requirements
Module: ps2_keydecode

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, key-event buffer depth in entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port code_valid  input  1  one-cycle strobe marking a new received PS/2 byte.
REQ-005 SHALL have port code_in  input  8  received scan-code byte, sampled when code_valid=1.
REQ-006 SHALL have port key_valid  output  1  high while buffer non-empty.
REQ-007 SHALL have port key_data  output  4  head-of-buffer key: 0-9 digit, 10 '+', 11 '-', 12 '*', 13 '/', 14 '=', 15 clear.
REQ-008 SHALL have port key_ready  input  1  consumer pop; pop occurs when key_valid&&key_ready.
REQ-009 SHALL have port overflow  output  1  one-cycle pulse when a mapped key is dropped because the buffer is full.

Function
REQ-010 SHALL run a 4-state prefix FSM: IDLE, EXT (after 0xE0), BRK (after 0xF0), EXT_BRK (after 0xE0 then 0xF0).
REQ-011 SHALL transition on code_valid only: IDLE+E0->EXT; IDLE+F0->BRK; EXT+F0->EXT_BRK; any other byte in any state -> IDLE after processing.
REQ-012 SHALL treat a byte received in IDLE/EXT as a make code and in BRK/EXT_BRK as a break code, with ext flag = (state is EXT or EXT_BRK).
REQ-013 SHALL map non-extended make codes: 45/16/1E/26/25/2E/36/3D/3E/46 -> 0..9; keypad 70/69/72/7A/6B/73/74/6C/75/7D -> 0..9; 79->'+'; 7B->'-'; 7C->'*'; 5A->'='; 76 and 66 -> clear.
REQ-014 SHALL map extended make codes: E0 4A->'/'; E0 5A->'='; all other extended codes unmapped.
REQ-015 SHALL ignore unmapped make codes and bytes AA, FA, FE, EE, E1 received in IDLE (state stays IDLE).
REQ-016 SHALL keep a held register {held_vld, held_ext, held_code[7:0]}; a mapped make whose {ext,code} equals the held value while held_vld=1 is a typematic repeat and SHALL be discarded.
REQ-017 SHALL on an accepted mapped make set held to {1,ext,code} and push the mapped key.
REQ-018 SHALL on a break code equal to held {ext,code} clear held_vld; a non-matching break leaves held unchanged; breaks never push.
REQ-019 SHALL give latency 1: code_valid at edge N makes key_valid=1 and key_data valid after edge N+1 when buffer was empty.
REQ-020 SHALL implement the buffer as a FIFO_DEPTH-entry circular FIFO with wrap-around read/write pointers and an occupancy count of width clog2(FIFO_DEPTH)+1.
REQ-021 SHALL on push when full and no pop drop the key, assert overflow for one cycle, and still update held.
REQ-022 SHALL on simultaneous push and pop when full accept both (count unchanged, no overflow).
REQ-023 SHALL on simultaneous push and pop when empty-to-one ignore the pop (key_valid=0 that cycle) and store the push.
REQ-024 SHALL hold key_data stable while key_valid=1 and key_ready=0.

Reset
REQ-025 SHALL when rst=0 at a rising clk edge set FSM=IDLE, held_vld=0, FIFO pointers and count=0, key_valid=0, key_data=0, overflow=0.
REQ-026 SHALL abandon any partial prefix sequence on reset mid-sequence (e.g. after E0), and ignore code_valid during the reset cycle.

Structure
REQ-027 SHALL place key encoding constants (KEY_ADD=10 .. KEY_CLR=15), prefix bytes E0/F0 and FSM state encodings in shared package ps2_pkg.
REQ-028 SHALL implement the FIFO as sub-module key_fifo (parameter DEPTH, width 4); mapping and FSM remain in ps2_keydecode.

Verification
REQ-029 SHALL cover: 16, F0 16 -> one key 1 pushed, held cleared; key_data=1 one cycle after first strobe.
REQ-030 SHALL cover: 16,16,16, F0 16, 16 -> exactly two key 1 events (repeats suppressed until break).
REQ-031 SHALL cover: E0 4A, E0 F0 4A, 5A, F0 5A -> keys 13 then 14; E0 F0 4A pushes nothing.
REQ-032 SHALL cover: key_ready=0, six distinct mapped makes (with breaks) at FIFO_DEPTH=4 -> four stored, overflow pulses twice, drain order 0,1,2,3.
REQ-033 SHALL cover: full FIFO, push and pop in same cycle -> count stays 4, no overflow, new key at tail.
REQ-034 SHALL cover: E0 then rst=0 one cycle, then 5A -> key 14 via non-extended path, key_valid=0 during reset.
